// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory-side blocks.
package mips_pkg;

    typedef enum logic [1:0] {MEM_IDLE, MEM_RD_WAIT, MEM_WR_BYTE} mem_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned CNT_W          = 4;

    // Little-endian byte lane select: lane 0 is the LSB of the word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [IDX_W-1:0]  idx);
        return BYTE_W'(w >> (BYTE_W * 32'(idx)));
    endfunction

endpackage

// File: rtl/mips_byte_ram.sv
// Byte-wide single-port RAM: synchronous write, registered read.
module mips_byte_ram
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    output logic [BYTE_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    // Read register only updates on a read, so the last byte read is held.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem_q[addr_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else         rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder: byte reads with configurable latency, word stores split
// into four little-endian byte writes, behind a req/ready handshake.
module mips_mem_responder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned READ_LAT  = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk_i_top,
    input  logic              rst_i_top,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [BYTE_W-1:0] rdata_o,
    output logic              wdone_o
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              wdone_q, wdone_d;

    logic              accept_c;
    logic              ram_we_c, ram_re_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [BYTE_W-1:0] ram_wdata_c;

    assign accept_c = req_i && ready_q;

    // Next-state, RAM control and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rvalid_d    = 1'b0;
        wdone_d     = 1'b0;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
        ram_addr_c  = addr_q;
        ram_wdata_c = word_byte(wdata_q, idx_q);

        unique case (state_q)
            MEM_IDLE: begin
                if (accept_c) begin
                    addr_d = addr_i;
                    if (we_i) begin
                        wdata_d = wdata_i;
                        idx_d   = '0;
                        state_d = MEM_WR_BYTE;
                    end else if (READ_LAT == 1) begin
                        ram_re_c   = 1'b1;
                        ram_addr_c = addr_i;
                        rvalid_d   = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(READ_LAT - 1);
                        state_d = MEM_RD_WAIT;
                    end
                end
            end
            MEM_RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    ram_re_c = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = MEM_IDLE;
                end
            end
            MEM_WR_BYTE: begin
                ram_we_c   = 1'b1;
                ram_addr_c = addr_q + ADDR_W'(idx_q);
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                    wdone_d = 1'b1;
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase

        ready_d = (state_d == MEM_IDLE);
    end

    always_ff @(posedge clk_i_top or negedge rst_i_top) begin
        if (!rst_i_top) begin
            state_q  <= MEM_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
        end
    end

    mips_byte_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk_i_top),
        .rst_ni  (rst_i_top),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (ram_addr_c),
        .wdata_i (ram_wdata_c),
        .rdata_o (rdata_o)
    );

    assign ready_o  = ready_q;
    assign rvalid_o = rvalid_q;
    assign wdone_o  = wdone_q;

    // Request strobe and accepted command fields must never be unknown.
    a_req_known: assert property (@(posedge clk_i_top) disable iff (!rst_i_top)
        ready_q |-> !$isunknown(req_i));
    a_cmd_known: assert property (@(posedge clk_i_top) disable iff (!rst_i_top)
        accept_c |-> !$isunknown({we_i, addr_i}));

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: READ_LAT=1 and READ_LAT=3 instances against an
// edge-timed transaction model, plus directed literal checks.
module tb_mips_mem_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [7:0]  addr  = '0;
    logic [31:0] wdata = '0;
    int          sel   = 0;
    logic        req0, req1;

    logic       ready_v  [2];
    logic       rvalid_v [2];
    logic       wdone_v  [2];
    logic [7:0] rdata_v  [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int rv_seen = 0;
    int wd_seen = 0;

    assign req0 = req && (sel == 0);
    assign req1 = req && (sel == 1);

    always #5 clk = ~clk;

    mips_mem_responder #(.ADDR_W(8), .READ_LAT(1), .INIT_FILE("")) u_lat1 (
        .clk_i_top(clk), .rst_i_top(rst_n), .req_i(req0), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .ready_o(ready_v[0]),
        .rvalid_o(rvalid_v[0]), .rdata_o(rdata_v[0]), .wdone_o(wdone_v[0]));

    mips_mem_responder #(.ADDR_W(8), .READ_LAT(3), .INIT_FILE("")) u_lat3 (
        .clk_i_top(clk), .rst_i_top(rst_n), .req_i(req1), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .ready_o(ready_v[1]),
        .rvalid_o(rvalid_v[1]), .rdata_o(rdata_v[1]), .wdone_o(wdone_v[1]));

    // ---------------- transaction model (time measured in clock edges) ----------------
    logic [7:0]  mm [2][256];
    longint      e_cnt = 0;
    longint      busy_until [2];
    longint      rd_edge [2];
    longint      wd_edge [2];
    longint      st_base [2];
    logic        st_act  [2];
    logic [7:0]  st_addr [2];
    logic [7:0]  rd_addr [2];
    logic [31:0] st_data [2];
    logic        ex_ready  [2];
    logic        ex_rvalid [2];
    logic        ex_wdone  [2];
    logic [7:0]  ex_rdata  [2];
    logic        m_acc     [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    initial begin
        logic r;
        int   b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    ex_ready[k]   = 1'b1;
                    ex_rvalid[k]  = 1'b0;
                    ex_wdone[k]   = 1'b0;
                    ex_rdata[k]   = 8'h00;
                    st_act[k]     = 1'b0;
                    rd_edge[k]    = -1;
                    wd_edge[k]    = -1;
                    busy_until[k] = 0;
                    m_acc[k]      = 1'b0;
                end
            end else begin
                e_cnt++;
                for (int k = 0; k < 2; k++) begin
                    r = (k == 0) ? req0 : req1;
                    m_acc[k] = r && ex_ready[k];
                    // store byte n lands on edge (accept + 1 + n)
                    if (st_act[k] && e_cnt > st_base[k] && e_cnt <= st_base[k] + 4) begin
                        b = int'(e_cnt - st_base[k] - 1);
                        mm[k][8'(int'(st_addr[k]) + b)] = st_data[k][8*b +: 8];
                        if (b == 3) st_act[k] = 1'b0;
                    end
                    if (m_acc[k]) begin
                        if (we) begin
                            st_act[k]     = 1'b1;
                            st_base[k]    = e_cnt;
                            st_addr[k]    = addr;
                            st_data[k]    = wdata;
                            wd_edge[k]    = e_cnt + 4;
                            busy_until[k] = e_cnt + 4;
                        end else begin
                            rd_edge[k]    = e_cnt + longint'(lat_of(k)) - 1;
                            rd_addr[k]    = addr;
                            busy_until[k] = rd_edge[k];
                        end
                    end
                    ex_wdone[k]  = (wd_edge[k] == e_cnt);
                    ex_rvalid[k] = (rd_edge[k] == e_cnt);
                    if (ex_rvalid[k]) ex_rdata[k] = mm[k][rd_addr[k]];
                    ex_ready[k]  = (e_cnt >= busy_until[k]);
                end
            end
        end
    end

    task automatic cmp(input string nm, input int k, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid_v[sel]) rv_seen++;
            if (wdone_v[sel])  wd_seen++;
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    cmp("ready_o",  k, int'(ready_v[k]),  int'(ex_ready[k]));
                    cmp("rvalid_o", k, int'(rvalid_v[k]), int'(ex_rvalid[k]));
                    cmp("wdone_o",  k, int'(wdone_v[k]),  int'(ex_wdone[k]));
                    cmp("rdata_o",  k, int'(rdata_v[k]),  int'(ex_rdata[k]));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_acc[sel] && n < 100);
        req = 1'b0;
        if (!m_acc[sel]) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout dut%0d: no accept within %0d cycles", sel, n);
        end
    endtask

    task automatic wait_pulse(input bit want_wdone, output int lat, output int low_rdy);
        lat = 0; low_rdy = 0;
        do begin
            @(negedge clk); lat++;
            if (!ready_v[sel]) low_rdy++;
        end while (!(want_wdone ? wdone_v[sel] : rvalid_v[sel]) && lat < 50);
        if (lat >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL response_timeout dut%0d: got none expected pulse", sel);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output int lat, output int lowr);
        issue(1'b0, a, 32'h0);
        wait_pulse(1'b0, lat, lowr);
        d = rdata_v[sel];
    endtask

    task automatic st(input logic [7:0] a, input logic [31:0] d, output int lat);
        int lowr;
        issue(1'b1, a, d);
        wait_pulse(1'b1, lat, lowr);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        int lat, lowr;
        rd(a, d, lat, lowr);
        cmp(nm, sel, int'(d), int'(exp));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int         lat, lowr, rv0, wd0;
        logic [7:0] d, pre20, pre42, pre43;
        logic       w;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cmp("rst_ready",  k, int'(ready_v[k]),  1);
            cmp("rst_rvalid", k, int'(rvalid_v[k]), 0);
            cmp("rst_wdone",  k, int'(wdone_v[k]),  0);
            cmp("rst_rdata",  k, int'(rdata_v[k]),  0);
        end

        // Fill both RAMs so every model byte is known, then plant 0xA7 at 0x05.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 64; i++) st(8'(4 * i), $urandom, lat);
            st(8'h05, 32'h0000_00A7, lat);
        end

        sel = 0;
        rd(8'h05, d, lat, lowr);
        cmp("rd_lat1_latency", 0, lat, 1);
        cmp("rd_lat1_data",    0, int'(d), 'hA7);

        sel = 1;
        rd(8'h05, d, lat, lowr);
        cmp("rd_lat3_latency",   1, lat, 3);
        cmp("rd_lat3_data",      1, int'(d), 'hA7);
        cmp("rd_lat3_ready_low", 1, lowr, 2);
        rd_chk("rd_lat3_06", 8'h06, 8'h00);

        sel = 0;
        st(8'h10, 32'hDEAD_BEEF, lat);
        cmp("st_latency", 0, lat, 5);
        cmp("model_mem10", 0, int'(mm[0][8'h10]), 'hEF);
        rd_chk("st_rd_10", 8'h10, 8'hEF);
        rd_chk("st_rd_11", 8'h11, 8'hBE);
        rd_chk("st_rd_12", 8'h12, 8'hAD);
        rd_chk("st_rd_13", 8'h13, 8'hDE);

        st(8'hFE, 32'h1122_3344, lat);
        cmp("model_mem01", 0, int'(mm[0][8'h01]), 'h11);
        rd_chk("wrap_FE", 8'hFE, 8'h44);
        rd_chk("wrap_FF", 8'hFF, 8'h33);
        rd_chk("wrap_00", 8'h00, 8'h22);
        rd_chk("wrap_01", 8'h01, 8'h11);

        // A read strobe during a store is dropped, not queued.
        pre20 = mm[0][8'h20];
        rv0   = rv_seen;
        issue(1'b1, 8'h30, 32'h5566_7788);
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 8'h20;
        @(negedge clk); req = 1'b0;
        wait_pulse(1'b1, lat, lowr);
        repeat (3) @(negedge clk);
        cmp("busy_no_rvalid", 0, rv_seen - rv0, 0);
        rd_chk("busy_rd_20", 8'h20, pre20);
        rd_chk("busy_rd_30", 8'h30, 8'h88);
        rd_chk("busy_rd_31", 8'h31, 8'h77);
        rd_chk("busy_rd_32", 8'h32, 8'h66);
        rd_chk("busy_rd_33", 8'h33, 8'h55);

        // Reset after two of the four byte writes.
        pre42 = mm[0][8'h42];
        pre43 = mm[0][8'h43];
        wd0   = wd_seen;
        issue(1'b1, 8'h40, 32'hCAFE_F00D);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        cmp("rst_mid_no_wdone", 0, wd_seen - wd0, 0);
        cmp("rst_mid_ready",    0, int'(ready_v[0]), 1);
        rd_chk("rst_mid_40", 8'h40, 8'h0D);
        rd_chk("rst_mid_41", 8'h41, 8'hF0);
        rd_chk("rst_mid_42", 8'h42, pre42);
        rd_chk("rst_mid_43", 8'h43, pre43);

        // Random traffic on each instance; outputs checked every cycle by the model.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            repeat (150) begin
                w = ($urandom_range(0, 2) == 0);
                issue(w, 8'($urandom), $urandom);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            repeat (8) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
